// File: rtl/uart_send_pkg.sv
// Shared types for the UART send queue: queued entry layout and serialiser states.
package uart_send_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef struct packed {
        logic        wide;
        logic [31:0] data;
    } send_entry_t;

    typedef enum logic [1:0] {IDLE, SEND, GUARD} send_state_t;

endpackage

// File: rtl/uart_send_queue_if.sv
// Core-side send port and UartTx-side byte port of the UART send queue.
interface uart_send_queue_if #(
    parameter int unsigned DEPTH_LOG2 = 8
);
    logic                  we;
    logic [31:0]           wd;
    logic                  wide;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  idle;
    logic                  bl_tx_start;
    logic [7:0]            bl_sdata;
    logic                  tx_busy;
    logic                  tx_start;
    logic [7:0]            sdata;

    modport master (
        output we, wd, wide, bl_tx_start, bl_sdata, tx_busy,
        input  full, count, overflow, idle, tx_start, sdata
    );

    modport slave (
        input  we, wd, wide, bl_tx_start, bl_sdata, tx_busy,
        output full, count, overflow, idle, tx_start, sdata
    );
endinterface

// File: rtl/send_fifo.sv
// Circular synchronous FIFO with combinational head read and a registered overflow pulse.
module send_fifo
    import uart_send_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter type entry_t = send_entry_t
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  entry_t              push_data,
    input  logic                pop,
    output entry_t              head,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic [DEPTH_LOG2:0] count
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    entry_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;
    logic                  do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    // A full FIFO refuses a write even when it pops in the same cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push && full;
            if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_send_queue.sv
// Queues core byte/word send requests and serialises them LSB first onto UartTx,
// merged with boot loader traffic which always wins the shared start strobe.
module uart_send_queue
    import uart_send_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input logic              clock,
    input logic              reset,
    uart_send_queue_if.slave bus
);
    send_entry_t wr_entry, head;
    logic        fifo_empty, pop, own_fire;
    send_state_t state_q, state_d;
    logic [31:0] sh_q, sh_d;
    logic [2:0]  rem_q, rem_d;

    assign wr_entry = '{wide: bus.wide, data: bus.wd};

    send_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .entry_t    (send_entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.we),
        .push_data (wr_entry),
        .pop       (pop),
        .head      (head),
        .full      (bus.full),
        .empty     (fifo_empty),
        .overflow  (bus.overflow),
        .count     (bus.count)
    );

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        rem_d    = rem_q;
        pop      = 1'b0;
        own_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = head.data;
                    rem_d   = head.wide ? 3'(BYTES_PER_WORD) : 3'd1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Boot loader or a busy UartTx defers the byte; it stays in sh until sent.
                own_fire = !bus.bl_tx_start && !bus.tx_busy;
                if (own_fire) begin
                    sh_d    = {8'h00, sh_q[31:8]};
                    rem_d   = rem_q - 3'd1;
                    state_d = GUARD;
                end
            end
            // One cycle for UartTx's registered busy to rise.
            GUARD:   state_d = (rem_q != 3'd0) ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.tx_start = bus.bl_tx_start | own_fire;
    assign bus.sdata    = bus.bl_tx_start ? bus.bl_sdata : sh_q[7:0];
    assign bus.idle     = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_send_queue.sv
// Directed bench for uart_send_queue with a small UartTx busy model and a tx_start logger.
module tb_uart_send_queue;
    localparam int unsigned DL = 2;

    logic clock = 1'b0;
    logic reset;
    logic model_en, force_busy;
    int   busy_cnt = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [7:0] log_q [$];
    logic       busy_log_q [$];
    int         cyc_log_q [$];

    uart_send_queue_if #(.DEPTH_LOG2(DL)) bus ();

    uart_send_queue #(.DEPTH_LOG2(DL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.tx_start) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    assign bus.tx_busy = force_busy | (model_en && busy_cnt != 0);

    always @(negedge clock) begin
        if (bus.tx_start === 1'b1) begin
            log_q.push_back(bus.sdata);
            busy_log_q.push_back(bus.tx_busy);
            cyc_log_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] log_at(input int i);
        return (i < log_q.size()) ? log_q[i] : 8'hxx;
    endfunction

    task automatic clear_log();
        log_q.delete();
        busy_log_q.delete();
        cyc_log_q.delete();
    endtask

    task automatic send(input logic [31:0] data, input logic w);
        bus.we = 1'b1;
        bus.wd = data;
        bus.wide = w;
        tick();
        bus.we = 1'b0;
    endtask

    initial begin
        int t0, g;
        logic [7:0] exp3 [5];
        reset = 1'b1;
        model_en = 1'b0;
        force_busy = 1'b0;
        bus.we = 1'b0;
        bus.wd = '0;
        bus.wide = 1'b0;
        bus.bl_tx_start = 1'b0;
        bus.bl_sdata = '0;

        // Reset state and live boot loader path during reset
        tick();
        tick();
        check("rst_full", bus.full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_idle", bus.idle, 1);
        check("rst_count", bus.count, 0);
        #2;
        bus.bl_tx_start = 1'b1;
        bus.bl_sdata = 8'h5A;
        #1;
        check("rst_bl_start", bus.tx_start, 1);
        check("rst_bl_sdata", bus.sdata, 8'h5A);
        bus.bl_tx_start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rst_no_start", bus.tx_start, 0);
        clear_log();

        // 1: single byte, first tx_start two cycles after we
        t0 = cyc;
        send(32'h0000_0041, 1'b0);
        repeat (10) tick();
        check("t1_nbytes", log_q.size(), 1);
        check("t1_byte", log_at(0), 8'h41);
        check("t1_latency", (cyc_log_q.size() > 0) ? cyc_log_q[0] - t0 : -1, 2);
        check("t1_idle", bus.idle, 1);

        // 2: word with UartTx busy 10 cycles per byte
        clear_log();
        model_en = 1'b1;
        send(32'h1122_3344, 1'b1);
        repeat (80) tick();
        check("t2_nbytes", log_q.size(), 4);
        check("t2_b0", log_at(0), 8'h44);
        check("t2_b1", log_at(1), 8'h33);
        check("t2_b2", log_at(2), 8'h22);
        check("t2_b3", log_at(3), 8'h11);
        for (int i = 0; i < busy_log_q.size(); i++) check("t2_busy_at_fire", busy_log_q[i], 0);
        for (int i = 1; i < cyc_log_q.size(); i++)
            check("t2_spacing", cyc_log_q[i] - cyc_log_q[i-1] >= 2, 1);
        check("t2_idle", bus.idle, 1);
        model_en = 1'b0;

        // 3: full/overflow; the first byte is popped into the shifter, so five fill the FIFO
        clear_log();
        force_busy = 1'b1;
        bus.we = 1'b1;
        bus.wide = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.wd = 32'hA0 + i;
            tick();
            if (i == 3) check("t3_not_full_yet", bus.full, 0);
        end
        check("t3_full", bus.full, 1);
        check("t3_count_full", bus.count, 4);
        check("t3_no_overflow_yet", bus.overflow, 0);
        bus.wd = 32'hA5;
        tick();
        bus.we = 1'b0;
        check("t3_overflow", bus.overflow, 1);
        check("t3_count_after_drop", bus.count, 4);
        tick();
        check("t3_overflow_pulse", bus.overflow, 0);
        check("t3_nothing_sent", log_q.size(), 0);
        force_busy = 1'b0;
        repeat (30) tick();
        exp3 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check("t3_nbytes", log_q.size(), 5);
        for (int i = 0; i < 5; i++) check("t3_order", log_at(i), exp3[i]);
        check("t3_idle", bus.idle, 1);

        // 4: boot loader wins the cycle own byte would fire
        clear_log();
        force_busy = 1'b1;
        send(32'h77, 1'b0);
        repeat (3) tick();
        check("t4_deferred", log_q.size(), 0);
        force_busy = 1'b0;
        bus.bl_tx_start = 1'b1;
        bus.bl_sdata = 8'h55;
        #1;
        check("t4_prio_start", bus.tx_start, 1);
        check("t4_prio_sdata", bus.sdata, 8'h55);
        tick();
        bus.bl_tx_start = 1'b0;
        force_busy = 1'b1;
        #1;
        check("t4_held_by_busy", bus.tx_start, 0);
        repeat (3) tick();
        force_busy = 1'b0;
        repeat (10) tick();
        check("t4_nbytes", log_q.size(), 2);
        check("t4_bl_byte", log_at(0), 8'h55);
        check("t4_own_byte", log_at(1), 8'h77);

        // 5: pop and write in the same cycle
        clear_log();
        force_busy = 1'b1;
        bus.we = 1'b1;
        bus.wide = 1'b0;
        bus.wd = 32'hB1;
        tick();
        check("t5_count_first", bus.count, 1);
        bus.wd = 32'hB2;
        tick();
        bus.we = 1'b0;
        check("t5_count_simul", bus.count, 1);
        tick();
        check("t5_count_hold", bus.count, 1);
        force_busy = 1'b0;
        repeat (15) tick();
        check("t5_nbytes", log_q.size(), 2);
        check("t5_b0", log_at(0), 8'hB1);
        check("t5_b1", log_at(1), 8'hB2);

        // 6: reset after two bytes of a word
        clear_log();
        model_en = 1'b1;
        send(32'hDEAD_BEEF, 1'b1);
        g = 0;
        while (log_q.size() < 2 && g < 200) begin
            tick();
            g++;
        end
        check("t6_two_sent", log_q.size(), 2);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t6_rst_no_start", bus.tx_start, 0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (60) tick();
        check("t6_nbytes", log_q.size(), 2);
        check("t6_b0", log_at(0), 8'hEF);
        check("t6_b1", log_at(1), 8'hBE);
        check("t6_count", bus.count, 0);
        check("t6_idle", bus.idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
